karatsuba_datapath_8bit: RTL and testbench
==========================================

Name: karatsuba_datapath_8bit

Overview:
- Datapath for the 8x8 sequential Karatsuba multiplier; the responder side of the control-unit strobe interface (LD_XY, LD_DE0, LD_A, LD_B, LD_DE1, LD_AB, LD_DE_ABshift, LD_RES, SELROM, SELSOMA).
- Captures X/Y, forms nibble sums, and time-shares one 5x5 multiplier and one adder/subtractor.
- Produces the 16-bit product P plus a valid flag and a protocol-error flag.
- Sits beside the control unit inside the multiplier top level.

Parameters:
- W, 8, operand width (fixed at 8; halves are W/2).

Ports:
- clk  in  1  rising-edge clock.
- RESET_N  in  1  asynchronous active-low reset.
- X  in  8  multiplicand.
- Y  in  8  multiplier.
- LD_XY, LD_DE0, LD_A, LD_B, LD_DE1, LD_AB, LD_DE_ABshift, LD_RES  in  1 each  load strobes from the control unit.
- SELROM  in  2  multiplier operand select.
- SELSOMA  in  2  adder operation select.
- P  out  16  product (the RES register).
- RES_VALID  out  1  P holds the result of the current operation.
- ERR  out  1  sticky protocol violation.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, RESET_N).
- Reset: all internal registers, P, RES_VALID and ERR go to 0 immediately. Reset asserted mid-operation discards all partial results.
- All strobes are sampled at the rising edge of clk. A strobe's effect is visible on the following cycle.
- Operand and sum loads:
  - LD_XY: XR<=X, YR<=Y; RES_VALID<=0; ERR<=0. XH/XL and YH/YL are the 4-bit halves of XR/YR.
  - LD_DE0: SX<=XH+XL and SY<=YH+YL, each 5 bits (max 30).
- Multiplier, PROD register (10 bits):
  - SELROM=1: PROD<=XH*YH.
  - SELROM=2: PROD<=XL*YL.
  - SELROM=3: PROD<=SX*SY.
  - SELROM=0: PROD holds.
- Products are loaded one edge after they are computed, because the control unit drops SELROM on the same edge it raises the load:
  - LD_A: A<=PROD[7:0].
  - LD_B: B<=PROD[7:0].
  - LD_DE1: DE<=PROD (10 bits, max 900).
- Adder, SUM register (16 bits):
  - SELSOMA=1: SUM<=A+B (max 450).
  - SELSOMA=2: SUM<=DE-AB, computed in 10 bits. The result is never negative for legal sequences (it equals XH*YL+XL*YH, at most 450).
  - SELSOMA=3: SUM<=(A<<8)+(MID<<4)+B. This is at most 65025 and never overflows 16 bits.
  - SELSOMA=0: SUM holds.
- Adder-result loads:
  - LD_AB: AB<=SUM[8:0].
  - LD_DE_ABshift: MID<=SUM[9:0].
  - LD_RES: P<=SUM; RES_VALID<=1. LD_RES held high for many cycles reloads the same value; this is legal.
- Latency: SELSOMA=3 at edge k gives P valid after edge k+1 (LD_RES edge). A full legal sequence is 14 cycles from LD_XY to RES_VALID.
- ERR rules:
  - Set when, at a sampled edge, two or more LD_* strobes are high, or SELROM!=0 and SELSOMA!=0 together, or SELSOMA=2 would produce DE<AB.
  - On an error edge all requested loads are still performed.
  - ERR stays set until the next LD_XY or reset. If LD_XY coincides with a violation, ERR is set, not cleared.
- Simultaneous LD_XY and LD_DE0: LD_DE0 uses the old XR/YR, and ERR is set.

Decomposition:
- Shared package karatsuba_pkg:
  - SELROM encodings ROM_NONE=0, ROM_HH=1, ROM_LL=2, ROM_SS=3.
  - SELSOMA encodings SOMA_NONE=0, SOMA_AB=1, SOMA_SUB=2, SOMA_FINAL=3.
  - Width constants: HALF=4, SUMW=5, PRODW=10, RESW=16.
- One sub-module, karatsuba_prod_unit: the 3-way operand mux, the 5x5 multiplier and the PROD register with its hold behaviour.

Test Plan:
- Legal control sequence, X=0xAB, Y=0xCD -> A=120, B=143, DE=525, AB=263, MID=262, P=0x88EF, RES_VALID=1, ERR=0.
- X=0xFF, Y=0xFF -> DE=900, MID=450, P=0xFE01. No overflow and ERR=0.
- X=0x00, Y=0x5A -> P=0x0000 and RES_VALID=1. Then a new LD_XY -> RES_VALID=0 while P still reads 0x0000.
- LD_A and LD_B high together, then SELROM=1 with SELSOMA=1 in the same cycle -> ERR=1 and stays set through LD_RES. Next LD_XY -> ERR=0.
- RESET_N pulsed low mid-sequence (after LD_B) -> P, RES_VALID and ERR go to 0 asynchronously. A rerun with X=3, Y=5 -> P=0x000F.
- LD_RES held high 5 cycles after completion -> P stable at the same value every cycle and RES_VALID stays 1.

Source files
------------

// File: rtl/karatsuba_pkg.sv
// rtl/karatsuba_pkg.sv - shared encodings and widths for the Karatsuba multiplier
package karatsuba_pkg;

    localparam int HALF  = 4;
    localparam int SUMW  = 5;
    localparam int PRODW = 10;
    localparam int RESW  = 16;

    typedef enum logic [1:0] {
        ROM_NONE = 2'd0,
        ROM_HH   = 2'd1,
        ROM_LL   = 2'd2,
        ROM_SS   = 2'd3
    } rom_sel_e;

    typedef enum logic [1:0] {
        SOMA_NONE  = 2'd0,
        SOMA_AB    = 2'd1,
        SOMA_SUB   = 2'd2,
        SOMA_FINAL = 2'd3
    } soma_sel_e;

endpackage

// File: rtl/karatsuba_datapath_8bit_if.sv
// rtl/karatsuba_datapath_8bit_if.sv - control-unit strobe bus between controller and datapath
interface karatsuba_datapath_8bit_if;
    import karatsuba_pkg::*;

    logic [7:0]      X;
    logic [7:0]      Y;
    logic            LD_XY;
    logic            LD_DE0;
    logic            LD_A;
    logic            LD_B;
    logic            LD_DE1;
    logic            LD_AB;
    logic            LD_DE_ABshift;
    logic            LD_RES;
    logic [1:0]      SELROM;
    logic [1:0]      SELSOMA;
    logic [RESW-1:0] P;
    logic            RES_VALID;
    logic            ERR;

    modport master (
        output X, Y, LD_XY, LD_DE0, LD_A, LD_B, LD_DE1, LD_AB, LD_DE_ABshift, LD_RES,
               SELROM, SELSOMA,
        input  P, RES_VALID, ERR
    );

    modport slave (
        input  X, Y, LD_XY, LD_DE0, LD_A, LD_B, LD_DE1, LD_AB, LD_DE_ABshift, LD_RES,
               SELROM, SELSOMA,
        output P, RES_VALID, ERR
    );

endinterface

// File: rtl/karatsuba_prod_unit.sv
// rtl/karatsuba_prod_unit.sv - shared 5x5 multiplier with operand mux and PROD register
module karatsuba_prod_unit
    import karatsuba_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  rom_sel_e         sel_i,
    input  logic [7:0]       xr_i,
    input  logic [7:0]       yr_i,
    input  logic [SUMW-1:0]  sx_i,
    input  logic [SUMW-1:0]  sy_i,
    output logic [PRODW-1:0] prod_o
);

    logic [SUMW-1:0]  op_a;
    logic [SUMW-1:0]  op_b;
    logic [PRODW-1:0] prod_d;
    logic [PRODW-1:0] prod_q;

    always_comb begin
        op_a = '0;
        op_b = '0;
        case (sel_i)
            ROM_HH: begin
                op_a = SUMW'(xr_i[7:HALF]);
                op_b = SUMW'(yr_i[7:HALF]);
            end
            ROM_LL: begin
                op_a = SUMW'(xr_i[HALF-1:0]);
                op_b = SUMW'(yr_i[HALF-1:0]);
            end
            ROM_SS: begin
                op_a = sx_i;
                op_b = sy_i;
            end
            default: ;
        endcase
    end

    always_comb begin
        prod_d = prod_q;
        if (sel_i != ROM_NONE) begin
            prod_d = PRODW'(op_a) * PRODW'(op_b);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prod_q <= '0;
        end else begin
            prod_q <= prod_d;
        end
    end

    assign prod_o = prod_q;

endmodule

// File: rtl/karatsuba_datapath_8bit.sv
// rtl/karatsuba_datapath_8bit.sv - Karatsuba 8x8 datapath responding to control-unit strobes
module karatsuba_datapath_8bit
    import karatsuba_pkg::*;
#(
    parameter int W = 8
) (
    input  logic                    clk,
    input  logic                    RESET_N,
    karatsuba_datapath_8bit_if.slave bus
);

    logic [W-1:0]     xr_q, yr_q;
    logic [SUMW-1:0]  sx_q, sy_q;
    logic [7:0]       a_q, b_q;
    logic [PRODW-1:0] de_q;
    logic [8:0]       ab_q;
    logic [PRODW-1:0] mid_q;
    logic [RESW-1:0]  sum_d, sum_q;
    logic [RESW-1:0]  p_q;
    logic             valid_d, valid_q;
    logic             err_d, err_q;
    logic [PRODW-1:0] prod;
    logic [PRODW-1:0] diff;
    logic [7:0]       ld_vec;
    logic             viol;
    soma_sel_e        soma;

    assign soma = soma_sel_e'(bus.SELSOMA);
    assign diff = de_q - PRODW'(ab_q);

    karatsuba_prod_unit u_prod (
        .clk    (clk),
        .rst_n  (RESET_N),
        .sel_i  (rom_sel_e'(bus.SELROM)),
        .xr_i   (xr_q),
        .yr_i   (yr_q),
        .sx_i   (sx_q),
        .sy_i   (sy_q),
        .prod_o (prod)
    );

    always_comb begin
        sum_d = sum_q;
        case (soma)
            SOMA_AB:    sum_d = RESW'(a_q) + RESW'(b_q);
            SOMA_SUB:   sum_d = RESW'(diff);
            SOMA_FINAL: sum_d = {a_q, 8'h00} + {2'b00, mid_q, 4'h0} + RESW'(b_q);
            default:    ;
        endcase
    end

    assign ld_vec = {bus.LD_XY, bus.LD_DE0, bus.LD_A, bus.LD_B,
                     bus.LD_DE1, bus.LD_AB, bus.LD_DE_ABshift, bus.LD_RES};

    // A violation on the same edge as LD_XY wins, so a bad restart stays flagged
    always_comb begin
        viol = ($countones(ld_vec) > 1)
            || ((bus.SELROM != 2'd0) && (bus.SELSOMA != 2'd0))
            || ((soma == SOMA_SUB) && (de_q < PRODW'(ab_q)));
        err_d = err_q;
        if (viol) begin
            err_d = 1'b1;
        end else if (bus.LD_XY) begin
            err_d = 1'b0;
        end
        valid_d = valid_q;
        if (bus.LD_XY) begin
            valid_d = 1'b0;
        end else if (bus.LD_RES) begin
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            xr_q    <= '0;
            yr_q    <= '0;
            sx_q    <= '0;
            sy_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            de_q    <= '0;
            ab_q    <= '0;
            mid_q   <= '0;
            sum_q   <= '0;
            p_q     <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            if (bus.LD_XY) begin
                xr_q <= bus.X;
                yr_q <= bus.Y;
            end
            if (bus.LD_DE0) begin
                sx_q <= SUMW'(xr_q[W-1:HALF]) + SUMW'(xr_q[HALF-1:0]);
                sy_q <= SUMW'(yr_q[W-1:HALF]) + SUMW'(yr_q[HALF-1:0]);
            end
            if (bus.LD_A)          a_q   <= prod[7:0];
            if (bus.LD_B)          b_q   <= prod[7:0];
            if (bus.LD_DE1)        de_q  <= prod;
            if (bus.LD_AB)         ab_q  <= sum_q[8:0];
            if (bus.LD_DE_ABshift) mid_q <= sum_q[PRODW-1:0];
            if (bus.LD_RES)        p_q   <= sum_q;
            sum_q   <= sum_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign bus.P         = p_q;
    assign bus.RES_VALID = valid_q;
    assign bus.ERR       = err_q;

endmodule

// File: tb/tb_karatsuba_datapath_8bit.sv
// tb/tb_karatsuba_datapath_8bit.sv - self-checking bench for the Karatsuba datapath
module tb_karatsuba_datapath_8bit;
    import karatsuba_pkg::*;

    localparam logic [7:0] L_XY  = 8'h80;
    localparam logic [7:0] L_DE0 = 8'h40;
    localparam logic [7:0] L_A   = 8'h20;
    localparam logic [7:0] L_B   = 8'h10;
    localparam logic [7:0] L_DE1 = 8'h08;
    localparam logic [7:0] L_AB  = 8'h04;
    localparam logic [7:0] L_SH  = 8'h02;
    localparam logic [7:0] L_RES = 8'h01;

    typedef struct {
        logic [7:0]  x;
        logic [7:0]  y;
        logic [15:0] p;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_vec = 0;
    int   n_fail = 0;
    vec_t vecs [6];

    always #5 clk = ~clk;

    karatsuba_datapath_8bit_if bus ();

    karatsuba_datapath_8bit #(.W(8)) dut (
        .clk     (clk),
        .RESET_N (rst_n),
        .bus     (bus)
    );

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, got, exp);
        end
    endtask

    task automatic step(input logic [7:0] ld, input logic [1:0] rom, input logic [1:0] soma);
        {bus.LD_XY, bus.LD_DE0, bus.LD_A, bus.LD_B,
         bus.LD_DE1, bus.LD_AB, bus.LD_DE_ABshift, bus.LD_RES} = ld;
        bus.SELROM  = rom;
        bus.SELSOMA = soma;
        @(posedge clk);
        #1;
        {bus.LD_XY, bus.LD_DE0, bus.LD_A, bus.LD_B,
         bus.LD_DE1, bus.LD_AB, bus.LD_DE_ABshift, bus.LD_RES} = 8'h00;
        bus.SELROM  = 2'd0;
        bus.SELSOMA = 2'd0;
    endtask

    task automatic load_xy(input logic [7:0] x, input logic [7:0] y);
        bus.X = x;
        bus.Y = y;
        step(L_XY, ROM_NONE, SOMA_NONE);
        chk("valid_cleared_by_ld_xy", 16'(bus.RES_VALID), 16'd0);
    endtask

    // Remaining 13 cycles of the legal controller sequence after LD_XY
    task automatic rest();
        step(L_DE0, ROM_NONE, SOMA_NONE);
        step(8'h00, ROM_HH,   SOMA_NONE);
        step(L_A,   ROM_NONE, SOMA_NONE);
        step(8'h00, ROM_LL,   SOMA_NONE);
        step(L_B,   ROM_NONE, SOMA_NONE);
        step(8'h00, ROM_SS,   SOMA_NONE);
        step(L_DE1, ROM_NONE, SOMA_NONE);
        step(8'h00, ROM_NONE, SOMA_AB);
        step(L_AB,  ROM_NONE, SOMA_NONE);
        step(8'h00, ROM_NONE, SOMA_SUB);
        step(L_SH,  ROM_NONE, SOMA_NONE);
        step(8'h00, ROM_NONE, SOMA_FINAL);
        step(L_RES, ROM_NONE, SOMA_NONE);
    endtask

    task automatic run(input logic [7:0] x, input logic [7:0] y, input logic [15:0] exp_p);
        load_xy(x, y);
        rest();
        chk($sformatf("p_%02h_x_%02h", x, y), bus.P, exp_p);
        chk("res_valid", 16'(bus.RES_VALID), 16'd1);
        chk("err_clear", 16'(bus.ERR), 16'd0);
    endtask

    initial begin
        logic [7:0] rx, ry;

        vecs[0] = '{x: 8'hAB, y: 8'hCD, p: 16'h88EF};
        vecs[1] = '{x: 8'hFF, y: 8'hFF, p: 16'hFE01};
        vecs[2] = '{x: 8'h00, y: 8'h5A, p: 16'h0000};
        vecs[3] = '{x: 8'h03, y: 8'h05, p: 16'h000F};
        vecs[4] = '{x: 8'h01, y: 8'hFF, p: 16'h00FF};
        vecs[5] = '{x: 8'hF0, y: 8'h0F, p: 16'h0E10};

        bus.X = 8'h00;
        bus.Y = 8'h00;
        {bus.LD_XY, bus.LD_DE0, bus.LD_A, bus.LD_B,
         bus.LD_DE1, bus.LD_AB, bus.LD_DE_ABshift, bus.LD_RES} = 8'h00;
        bus.SELROM  = 2'd0;
        bus.SELSOMA = 2'd0;

        #12;
        chk("reset_p", bus.P, 16'h0000);
        chk("reset_valid", 16'(bus.RES_VALID), 16'd0);
        chk("reset_err", 16'(bus.ERR), 16'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) begin
            run(vecs[i].x, vecs[i].y, vecs[i].p);
        end

        // Zero result stays on P while a new operation starts
        run(8'h00, 8'h5A, 16'h0000);
        load_xy(8'h12, 8'h34);
        chk("p_kept_after_ld_xy", bus.P, 16'h0000);
        rest();
        chk("p_12_x_34", bus.P, 16'(8'h12 * 8'h34));

        for (int i = 0; i < 5; i++) begin
            step(L_RES, ROM_NONE, SOMA_NONE);
            chk("ld_res_hold_p", bus.P, 16'h03A8);
            chk("ld_res_hold_valid", 16'(bus.RES_VALID), 16'd1);
        end

        // Protocol violations are sticky until the next clean LD_XY
        load_xy(8'hAB, 8'hCD);
        step(L_A | L_B, ROM_NONE, SOMA_NONE);
        chk("err_two_loads", 16'(bus.ERR), 16'd1);
        step(8'h00, ROM_HH, SOMA_AB);
        chk("err_rom_and_soma", 16'(bus.ERR), 16'd1);
        rest();
        chk("err_sticky_through_res", 16'(bus.ERR), 16'd1);
        chk("p_after_err_seq", bus.P, 16'h88EF);
        load_xy(8'h03, 8'h05);
        chk("err_cleared_by_ld_xy", 16'(bus.ERR), 16'd0);
        rest();
        chk("p_3_x_5", bus.P, 16'h000F);

        // LD_XY together with LD_DE0 is itself a violation
        bus.X = 8'hFF;
        bus.Y = 8'hFF;
        step(L_XY | L_DE0, ROM_NONE, SOMA_NONE);
        chk("err_xy_with_de0", 16'(bus.ERR), 16'd1);

        // Subtract with DE < AB: AB=450 left from FF*FF, DE=(1+1)*(1+1)=4
        run(8'hFF, 8'hFF, 16'hFE01);
        load_xy(8'h11, 8'h11);
        step(L_DE0, ROM_NONE, SOMA_NONE);
        step(8'h00, ROM_SS, SOMA_NONE);
        step(L_DE1, ROM_NONE, SOMA_NONE);
        chk("err_before_bad_sub", 16'(bus.ERR), 16'd0);
        step(8'h00, ROM_NONE, SOMA_SUB);
        chk("err_de_lt_ab", 16'(bus.ERR), 16'd1);

        // Asynchronous reset mid-sequence with P, RES_VALID and ERR all set
        run(8'hFF, 8'hFF, 16'hFE01);
        load_xy(8'hAB, 8'hCD);
        step(L_DE0, ROM_NONE, SOMA_NONE);
        step(8'h00, ROM_HH, SOMA_NONE);
        step(L_A, ROM_NONE, SOMA_NONE);
        step(8'h00, ROM_LL, SOMA_NONE);
        step(L_B | L_RES, ROM_NONE, SOMA_NONE);
        chk("pre_reset_err", 16'(bus.ERR), 16'd1);
        chk("pre_reset_valid", 16'(bus.RES_VALID), 16'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_reset_p", bus.P, 16'h0000);
        chk("async_reset_valid", 16'(bus.RES_VALID), 16'd0);
        chk("async_reset_err", 16'(bus.ERR), 16'd0);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run(8'h03, 8'h05, 16'h000F);

        for (int i = 0; i < 30; i++) begin
            rx = 8'($urandom_range(0, 255));
            ry = 8'($urandom_range(0, 255));
            run(rx, ry, 16'(rx) * 16'(ry));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
